vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 13, word address width; DATA_W, 16, data width; STARVE_LIMIT, 64, consecutive denied cycles before the system port is forced a slot.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 p_rden  in  1  pixel read strobe from the VGA.
REQ-005 p_addr  in  ADDR_W  pixel read address.
REQ-006 p_rdata  out  DATA_W  pixel read data.
REQ-007 p_miss  out  1  pixel read was dropped; p_rdata repeats the previous word.
REQ-008 s_write  in  1  system write strobe.
REQ-009 s_read  in  1  system read strobe.
REQ-010 s_addr  in  ADDR_W  system address.
REQ-011 s_din  in  DATA_W  system write data.
REQ-012 s_dout  out  DATA_W  last system read data.
REQ-013 s_busy  out  1  system request in flight; new strobes are ignored.
REQ-014 ram_addr  out  ADDR_W  single-port RAM address.
REQ-015 ram_we  out  1  RAM write enable.
REQ-016 ram_wdata  out  DATA_W  RAM write data.
REQ-017 ram_rdata  in  DATA_W  RAM read data, valid one cycle after the address.

Function
REQ-018 The arbiter SHALL grant exactly one RAM slot per cycle: either PIX, SYS or none.
REQ-019 Acceptance: in a cycle with s_busy=0 and (s_write|s_read), the arbiter SHALL register addr, data and op into a one-entry buffer; if both strobes are high the op SHALL be write and s_read is ignored.
REQ-020 Strobes while s_busy=1 SHALL be ignored with no side effect.
REQ-021 States: IDLE (no buffered request), PEND (buffered request awaiting a slot), RDWAIT (system read issued, data returning).
REQ-022 Transitions: IDLE->PEND on acceptance; PEND->IDLE on write grant; PEND->RDWAIT on read grant; RDWAIT->IDLE unconditionally after one cycle.
REQ-023 Slot choice in PEND: PIX if p_rden=1 and starve count < STARVE_LIMIT, else SYS; in IDLE/RDWAIT: PIX if p_rden=1, else none.
REQ-024 The starve counter SHALL increment each PEND cycle in which PIX wins, clear on SYS grant, and saturate at STARVE_LIMIT.
REQ-025 PIX slot: ram_addr=p_addr, ram_we=0; p_rdata SHALL equal ram_rdata in the following cycle with p_miss=0.
REQ-026 Dropped pixel (p_rden=1 in a SYS slot): the next cycle SHALL have p_miss=1, and p_rdata SHALL hold the last delivered pixel word.
REQ-027 The hold register SHALL capture ram_rdata after every PIX slot.
REQ-028 SYS write slot: ram_addr=buffered addr, ram_we=1, ram_wdata=buffered data, all in the same cycle.
REQ-029 SYS read slot at cycle M: ram_we=0; s_dout SHALL be loaded from ram_rdata at the end of M+1 and be visible at M+2.
REQ-030 s_busy SHALL be registered: high from the cycle after acceptance through the write-grant cycle, or through cycle M+1 for a read.
REQ-031 No-grant cycles: ram_we=0, ram_addr=p_addr.
REQ-032 ram_we SHALL never be high outside a SYS write slot.
REQ-033 Minimum system latency: write issued at acceptance+1; read data visible at acceptance+3.

Reset
REQ-034 rst_n low SHALL immediately force: state IDLE, s_busy=0, s_dout=0, p_rdata/hold=0, p_miss=0, ram_we=0, starve count 0.
REQ-035 A buffered or in-flight request SHALL be discarded on reset and never written.

Structure
REQ-036 Package vram_pkg SHALL hold ADDR_W/DATA_W defaults and the state enum {IDLE, PEND, RDWAIT}.
REQ-037 The starve counter SHALL be the sub-module vram_starve_ctr (inc, clr, saturating, limit flag).

Verification
REQ-038 Idle write: s_write, addr 0x0010, data 0xBEEF, p_rden=0 -> ram_we=1, ram_addr=0x0010 next cycle; s_busy high exactly 1 cycle.
REQ-039 Read-back: s_read addr 0x0010 with no pixel traffic -> s_dout=0xBEEF three cycles after the strobe; s_busy high 2 cycles.
REQ-040 Contention: p_rden held high, write pending, STARVE_LIMIT=4 -> 4 PIX slots, then the SYS write; p_miss=1 for one cycle; p_rdata equals the prior word.
REQ-041 Ignore: a second s_write while s_busy=1 -> RAM contents are unchanged at that address; exactly one write occurs.
REQ-042 Both strobes: s_write=s_read=1 -> one write, s_dout unchanged.
REQ-043 Reset mid-PEND: rst_n low while a write is pending under pixel traffic -> ram_we is never asserted; all outputs return to 0.

Source files
------------

// File: rtl/vram_pkg.sv
// vram_pkg: shared widths and enums for the VRAM arbiter.
//   VRAM_ADDR_W / VRAM_DATA_W : default word address / data widths
//   state_e : arbiter FSM state
//   slot_e  : owner of the RAM slot in the current cycle
package vram_pkg;

   localparam int VRAM_ADDR_W = 13;
   localparam int VRAM_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      RDWAIT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SLOT_NONE = 2'd0,
      SLOT_PIX  = 2'd1,
      SLOT_SYS  = 2'd2
   } slot_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: pixel port, system port and single-port RAM port of the arbiter.
//   slave  modport : arbiter side (drives p_rdata/p_miss, s_dout/s_busy, ram_*)
//   master modport : environment side (VGA, system bus, RAM)
interface vram_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16
);
   logic              p_rden;
   logic [ADDR_W-1:0] p_addr;
   logic [DATA_W-1:0] p_rdata;
   logic              p_miss;

   logic              s_write;
   logic              s_read;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_din;
   logic [DATA_W-1:0] s_dout;
   logic              s_busy;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  p_rden, p_addr, s_write, s_read, s_addr, s_din, ram_rdata,
      output p_rdata, p_miss, s_dout, s_busy, ram_addr, ram_we, ram_wdata
   );

   modport master (
      output p_rden, p_addr, s_write, s_read, s_addr, s_din, ram_rdata,
      input  p_rdata, p_miss, s_dout, s_busy, ram_addr, ram_we, ram_wdata
   );
endinterface

// File: rtl/vram_starve_ctr.sv
// vram_starve_ctr: saturating count of pending cycles in which the system port lost.
//   clk, rst_n : clock, async active-low reset
//   i_inc      : count one more denied cycle (saturates at LIMIT)
//   i_clr      : clear (wins over i_inc)
//   o_limit    : count has reached LIMIT
module vram_starve_ctr #(
   parameter int LIMIT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_limit
);
   localparam int CW = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(LIMIT);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != LIM)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_limit = (r_cnt == LIM);
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port RAM between a VGA pixel reader and a
// system read/write port, one slot per cycle. Pixels normally win; a pending
// system request is forced through after STARVE_LIMIT denied cycles.
//   clk, rst_n : clock, async active-low reset
//   bus        : vram_arbiter_if.slave (pixel, system and RAM signals)
//
//   state  | meaning
//   IDLE   | no buffered system request; strobes accepted
//   PEND   | request buffered, waiting for a SYS slot
//   RDWAIT | system read issued last cycle, RAM data returning
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int ADDR_W       = VRAM_ADDR_W,
   parameter int DATA_W       = VRAM_DATA_W,
   parameter int STARVE_LIMIT = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   vram_arbiter_if.slave bus
);
   state_e            r_state;
   state_e            w_next;
   slot_e             w_slot;

   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_op_wr;
   logic [DATA_W-1:0] r_hold;
   logic [DATA_W-1:0] r_sdout;
   logic              r_pix_slot;
   logic              r_miss;

   logic              w_accept;
   logic              w_starved;
   logic              w_inc;
   logic              w_clr;

   assign w_accept = (r_state == IDLE) && (bus.s_write || bus.s_read);

   always_comb begin
      w_next = r_state;
      w_slot = SLOT_NONE;
      case (r_state)
         IDLE: begin
            if (bus.p_rden) w_slot = SLOT_PIX;
            if (w_accept)   w_next = PEND;
         end
         PEND: begin
            if (bus.p_rden && !w_starved) begin
               w_slot = SLOT_PIX;
            end else begin
               w_slot = SLOT_SYS;
               w_next = r_op_wr ? IDLE : RDWAIT;
            end
         end
         RDWAIT: begin
            if (bus.p_rden) w_slot = SLOT_PIX;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_inc = (r_state == PEND) && (w_slot == SLOT_PIX);
   assign w_clr = (w_slot == SLOT_SYS);

   vram_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_inc),
      .i_clr   (w_clr),
      .o_limit (w_starved)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_data     <= '0;
         r_op_wr    <= 1'b0;
         r_hold     <= '0;
         r_sdout    <= '0;
         r_pix_slot <= 1'b0;
         r_miss     <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_addr  <= bus.s_addr;
            r_data  <= bus.s_din;
            r_op_wr <= bus.s_write;   // write wins when both strobes are high
         end
         r_pix_slot <= (w_slot == SLOT_PIX);
         r_miss     <= bus.p_rden && (w_slot == SLOT_SYS);
         if (r_pix_slot)          r_hold  <= bus.ram_rdata;
         if (r_state == RDWAIT)   r_sdout <= bus.ram_rdata;
      end
   end

   // Fresh pixel data comes straight from the RAM in the cycle after a PIX
   // slot; otherwise the last delivered word is repeated.
   assign bus.p_rdata   = r_pix_slot ? bus.ram_rdata : r_hold;
   assign bus.p_miss    = r_miss;
   assign bus.s_dout    = r_sdout;
   assign bus.s_busy    = (r_state != IDLE);

   assign bus.ram_addr  = (w_slot == SLOT_SYS) ? r_addr : bus.p_addr;
   assign bus.ram_we    = (w_slot == SLOT_SYS) && r_op_wr;
   assign bus.ram_wdata = r_data;
endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
   localparam int AW = 13;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Single-port RAM model: synchronous read, data valid one cycle after address.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   int wr_count = 0;
   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h5A00 + 16'(i[7:0]);
      bus.ram_rdata = '0;
   end
   always @(posedge clk) begin
      if (bus.ram_we) begin
         mem[bus.ram_addr] <= bus.ram_wdata;
         wr_count <= wr_count + 1;
      end
      bus.ram_rdata <= mem[bus.ram_addr];
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic          p_rden;
      logic [AW-1:0] p_addr;
      logic          s_write;
      logic          s_read;
      logic [AW-1:0] s_addr;
      logic [DW-1:0] s_din;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic          e_busy;
      logic          e_miss;
      logic [DW-1:0] e_dout;
      logic [DW-1:0] e_prdata;
   } vec_t;

   function automatic vec_t mk(input logic pr, input logic [AW-1:0] pa,
                               input logic sw, input logic sr,
                               input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                               input logic we, input logic [AW-1:0] ea,
                               input logic bs, input logic ms,
                               input logic [DW-1:0] dout, input logic [DW-1:0] prd);
      vec_t v;
      v.p_rden = pr; v.p_addr = pa; v.s_write = sw; v.s_read = sr;
      v.s_addr = sa; v.s_din = sd; v.e_we = we; v.e_addr = ea;
      v.e_busy = bs; v.e_miss = ms; v.e_dout = dout; v.e_prdata = prd;
      return v;
   endfunction

   task automatic drive(input logic pr, input logic [AW-1:0] pa, input logic sw,
                        input logic sr, input logic [AW-1:0] sa, input logic [DW-1:0] sd);
      bus.p_rden = pr; bus.p_addr = pa; bus.s_write = sw;
      bus.s_read = sr; bus.s_addr = sa; bus.s_din = sd;
   endtask

   task automatic chk_all(input string tag, input logic we, input logic [AW-1:0] a,
                          input logic bs, input logic ms,
                          input logic [DW-1:0] dout, input logic [DW-1:0] prd);
      chk({tag, " ram_we"},   32'(bus.ram_we),   32'(we));
      chk({tag, " ram_addr"}, 32'(bus.ram_addr), 32'(a));
      chk({tag, " s_busy"},   32'(bus.s_busy),   32'(bs));
      chk({tag, " p_miss"},   32'(bus.p_miss),   32'(ms));
      chk({tag, " s_dout"},   32'(bus.s_dout),   32'(dout));
      chk({tag, " p_rdata"},  32'(bus.p_rdata),  32'(prd));
   endtask

   vec_t vt [15];

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr0;
      // idle write, read-back, pixel reads, both strobes
      vt[0]  = mk(0, 0,     0, 0, 0,     0,       0, 0,     0, 0, 0,       0);
      vt[1]  = mk(0, 0,     1, 0, 13'h10, 16'hBEEF, 0, 0,   0, 0, 0,       0);
      vt[2]  = mk(0, 0,     0, 0, 0,     0,       1, 13'h10, 1, 0, 0,      0);
      vt[3]  = mk(0, 0,     0, 0, 0,     0,       0, 0,     0, 0, 0,       0);
      vt[4]  = mk(0, 0,     0, 1, 13'h10, 0,      0, 0,     0, 0, 0,       0);
      vt[5]  = mk(0, 0,     0, 0, 0,     0,       0, 13'h10, 1, 0, 0,      0);
      vt[6]  = mk(0, 0,     0, 0, 0,     0,       0, 0,     1, 0, 0,       0);
      vt[7]  = mk(0, 0,     0, 0, 0,     0,       0, 0,     0, 0, 16'hBEEF, 0);
      vt[8]  = mk(1, 13'h20, 0, 0, 0,    0,       0, 13'h20, 0, 0, 16'hBEEF, 0);
      vt[9]  = mk(1, 13'h21, 0, 0, 0,    0,       0, 13'h21, 0, 0, 16'hBEEF, 16'h5A20);
      vt[10] = mk(0, 0,     0, 0, 0,     0,       0, 0,     0, 0, 16'hBEEF, 16'h5A21);
      vt[11] = mk(0, 0,     0, 0, 0,     0,       0, 0,     0, 0, 16'hBEEF, 16'h5A21);
      vt[12] = mk(0, 0,     1, 1, 13'h30, 16'h1234, 0, 0,   0, 0, 16'hBEEF, 16'h5A21);
      vt[13] = mk(0, 0,     0, 0, 0,     0,       1, 13'h30, 1, 0, 16'hBEEF, 16'h5A21);
      vt[14] = mk(0, 0,     0, 0, 0,     0,       0, 0,     0, 0, 16'hBEEF, 16'h5A21);

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1 chk_all("reset", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         drive(vt[i].p_rden, vt[i].p_addr, vt[i].s_write, vt[i].s_read, vt[i].s_addr, vt[i].s_din);
         #1 chk_all($sformatf("vec%0d", i), vt[i].e_we, vt[i].e_addr, vt[i].e_busy,
                    vt[i].e_miss, vt[i].e_dout, vt[i].e_prdata);
      end
      chk("mem[0x10]", 32'(mem[13'h10]), 32'h0000BEEF);
      chk("mem[0x30]", 32'(mem[13'h30]), 32'h00001234);

      // contention: write pending under continuous pixel traffic, limit 4
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         drive(1, 13'(13'h40 + k), (k == 0), 0, 13'h50, 16'hCAFE);
         #1;
         chk($sformatf("cont%0d ram_we", k), 32'(bus.ram_we), 32'(k == 5));
         chk($sformatf("cont%0d ram_addr", k), 32'(bus.ram_addr),
             (k == 5) ? 32'h50 : 32'(32'h40 + k));
         chk($sformatf("cont%0d s_busy", k), 32'(bus.s_busy), 32'(k >= 1 && k <= 5));
         chk($sformatf("cont%0d p_miss", k), 32'(bus.p_miss), 32'(k == 6));
         if (k >= 1 && k <= 5)
            chk($sformatf("cont%0d p_rdata", k), 32'(bus.p_rdata), 32'(32'h5A40 + k - 1));
         if (k == 6) chk("cont6 p_rdata held", 32'(bus.p_rdata), 32'h5A44);
         if (k == 7) chk("cont7 p_rdata", 32'(bus.p_rdata), 32'h5A46);
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      #1 chk("mem[0x50]", 32'(mem[13'h50]), 32'h0000CAFE);

      // second write while busy is ignored
      wr0 = wr_count;
      @(negedge clk);
      drive(1, 0, 1, 0, 13'h60, 16'h1111);
      #1 chk("ign0 s_busy", 32'(bus.s_busy), 0);
      @(negedge clk);
      drive(1, 0, 1, 0, 13'h60, 16'h2222);
      #1 chk("ign1 s_busy", 32'(bus.s_busy), 1);
      chk("ign1 ram_we", 32'(bus.ram_we), 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      #1 chk("ign2 ram_we", 32'(bus.ram_we), 1);
      chk("ign2 ram_wdata", 32'(bus.ram_wdata), 32'h1111);
      @(negedge clk);
      #1 chk("ign3 s_busy", 32'(bus.s_busy), 0);
      chk("ign3 ram_we", 32'(bus.ram_we), 0);
      repeat (3) @(negedge clk);
      chk("ign writes", 32'(wr_count - wr0), 1);
      chk("mem[0x60]", 32'(mem[13'h60]), 32'h00001111);

      // reset while a write is pending under pixel traffic
      wr0 = wr_count;
      @(negedge clk);
      drive(1, 13'h10, 1, 0, 13'h70, 16'h7777);
      @(negedge clk);
      drive(1, 13'h10, 0, 0, 0, 0);
      #1 chk("rst pre s_busy", 32'(bus.s_busy), 1);
      #1 rst_n = 1'b0;
      #1 chk_all("rst_async", 0, 13'h10, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      repeat (4) @(negedge clk);
      #1 chk_all("rst_post", 0, 0, 0, 0, 0, 0);
      chk("rst writes", 32'(wr_count - wr0), 0);
      chk("mem[0x70]", 32'(mem[13'h70]), 32'h00005A70);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
